// File: rtl/mem_stage.sv
// Memory stage: issues aligned loads/stores to a handshaked data memory, formats
// load data, and retires one result per instruction to writeback with exception pulses.
//
// state | meaning
// IDLE  | ready to accept an EX result; non-memory and misaligned ops retire next cycle
// WAIT  | memory request outstanding, upstream stalled until ack or timeout
module mem_stage #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        exc_misalign,
    output logic        exc_bus
);

    // Counter only needs to reach ACK_TIMEOUT-1: the last WAIT cycle is detected by compare.
    localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;

    logic        op_load;
    logic        op_reg_write;
    logic [2:0]  op_funct3;
    logic [4:0]  op_rd;
    logic [1:0]  op_off;

    logic        accept;
    logic        is_mem;
    logic        misalign;
    logic        timeout;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] load_shift;
    logic [31:0] load_val;

    assign stall    = (state == WAIT);
    assign accept   = in_valid && (state == IDLE);
    assign is_mem   = mem_read || mem_write;
    assign misalign = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                      (funct3[1] && (alu_result[1:0] != 2'b00));
    assign timeout  = (wait_cnt == CNT_LAST);

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data;
        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << alu_result[1:0];
                    st_wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    st_be    = 4'b0011 << alu_result[1:0];
                    st_wdata = {2{store_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        load_shift = dmem_rdata >> {op_off, 3'b000};
        load_val   = load_shift;
        case (op_funct3)
            3'b000:  load_val = {{24{load_shift[7]}}, load_shift[7:0]};
            3'b100:  load_val = {24'h0, load_shift[7:0]};
            3'b001:  load_val = {{16{load_shift[15]}}, load_shift[15:0]};
            3'b101:  load_val = {16'h0, load_shift[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept && is_mem && !misalign) state_next = WAIT;
            WAIT: if (dmem_ack || timeout) state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt     <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'h0;
            dmem_be      <= 4'h0;
            dmem_wdata   <= 32'h0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'h0;
            wb_reg_write <= 1'b0;
            wb_data      <= 32'h0;
            exc_misalign <= 1'b0;
            exc_bus      <= 1'b0;
            op_load      <= 1'b0;
            op_reg_write <= 1'b0;
            op_funct3    <= 3'h0;
            op_rd        <= 5'h0;
            op_off       <= 2'h0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            exc_misalign <= 1'b0;
            exc_bus      <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    if (!is_mem || misalign) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= alu_result;
                        wb_rd        <= rd;
                        wb_reg_write <= reg_write && !is_mem;
                        exc_misalign <= is_mem;
                    end else begin
                        dmem_req     <= 1'b1;
                        dmem_we      <= mem_write;
                        dmem_addr    <= {alu_result[31:2], 2'b00};
                        dmem_be      <= st_be;
                        dmem_wdata   <= mem_write ? st_wdata : 32'h0;
                        wait_cnt     <= '0;
                        op_load      <= !mem_write;
                        op_reg_write <= reg_write;
                        op_funct3    <= funct3;
                        op_rd        <= rd;
                        op_off       <= alu_result[1:0];
                    end
                end
            end else begin
                if (dmem_ack) begin
                    // Ack beats a simultaneous timeout.
                    dmem_req     <= 1'b0;
                    dmem_we      <= 1'b0;
                    wb_valid     <= 1'b1;
                    wb_rd        <= op_rd;
                    wb_reg_write <= op_load && op_reg_write;
                    wb_data      <= op_load ? load_val : 32'h0;
                end else if (timeout) begin
                    dmem_req     <= 1'b0;
                    dmem_we      <= 1'b0;
                    wb_valid     <= 1'b1;
                    wb_rd        <= op_rd;
                    wb_data      <= 32'h0;
                    exc_bus      <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, randomized ops against a
// behavioural model, and hand sequences for reset, ignored inputs and handshake corners.
module tb_mem_stage;

    localparam int TO = 15;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        exc_misalign;
    logic        exc_bus;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_result(alu_result),
        .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .rd(rd), .reg_write(reg_write), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .exc_misalign(exc_misalign), .exc_bus(exc_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        rw;
        int          ack_at;   // WAIT cycle carrying ack; 0 = never
    } stim_t;

    typedef struct {
        int          stall;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic [31:0] wb;
        logic        chk_wb;
        logic        rw;
        logic        mis;
        logic        bus;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    typedef struct {
        int          stall;
        logic        req;
        logic        we;
        logic        stable;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        wbv;
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
        logic        bus;
        logic        req_after;
        logic        fall;
    } obs_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural expectation built from the access rules with plain arithmetic.
    function automatic exp_t model(input stim_t s);
        exp_t        e;
        int          size;
        int          off;
        logic [31:0] v;
        e = '{default: 0};
        size = (s.f3[1:0] == 2'b00) ? 1 : (s.f3[1:0] == 2'b01) ? 2 : 4;
        off  = int'(s.addr % 4);
        if (!(s.mr || s.mw)) begin
            e.wb = s.addr; e.chk_wb = 1'b1; e.rw = s.rw;
        end else if ((off % size) != 0) begin
            e.mis = 1'b1;
        end else begin
            e.req  = 1'b1;
            e.we   = s.mw;
            e.addr = s.addr - 32'(off);
            if (s.mw) begin
                e.chk_wdata = 1'b1;
                e.be = (size == 4) ? 4'hF : 4'(((1 << size) - 1) << off);
                if (size == 1)      e.wdata = {24'h0, s.sdata[7:0]} * 32'h01010101;
                else if (size == 2) e.wdata = {16'h0, s.sdata[15:0]} * 32'h00010001;
                else                e.wdata = s.sdata;
            end else begin
                e.be = 4'hF;
            end
            if (s.ack_at < 1 || s.ack_at > TO) begin
                e.stall = TO; e.bus = 1'b1;
            end else begin
                e.stall = s.ack_at;
                if (!s.mw) begin
                    v = s.rdata >> (8 * off);
                    if (size == 1) begin
                        v = v & 32'hFF;
                        if (!s.f3[2] && v[7]) v = v | 32'hFFFFFF00;
                    end else if (size == 2) begin
                        v = v & 32'hFFFF;
                        if (!s.f3[2] && v[15]) v = v | 32'hFFFF0000;
                    end
                    e.wb = v; e.chk_wb = 1'b1; e.rw = s.rw;
                end
            end
        end
        return e;
    endfunction

    task automatic do_op(input stim_t s, output obs_t o);
        int cyc;
        @(negedge clk);
        in_valid = 1'b1; mem_read = s.mr; mem_write = s.mw; funct3 = s.f3;
        alu_result = s.addr; store_data = s.sdata; rd = s.rd; reg_write = s.rw;
        @(negedge clk);
        in_valid = 1'b0;
        alu_result = $urandom; store_data = $urandom; rd = 5'($urandom);
        funct3 = 3'($urandom); reg_write = 1'($urandom);
        o = '{default: 0};
        o.req = dmem_req; o.we = dmem_we; o.addr = dmem_addr; o.be = dmem_be;
        o.wdata = dmem_wdata; o.stable = 1'b1;
        cyc = 0;
        while (stall === 1'b1 && cyc < 40) begin
            cyc++;
            if (dmem_req !== o.req || dmem_we !== o.we || dmem_addr !== o.addr ||
                dmem_be !== o.be || dmem_wdata !== o.wdata) o.stable = 1'b0;
            dmem_ack   = (cyc == s.ack_at);
            dmem_rdata = (cyc == s.ack_at) ? s.rdata : $urandom;
            @(negedge clk);
            dmem_ack = 1'b0;
        end
        o.stall = cyc;
        o.wbv = wb_valid; o.wb = wb_data; o.rd = wb_rd; o.rw = wb_reg_write;
        o.mis = exc_misalign; o.bus = exc_bus; o.req_after = dmem_req;
        @(negedge clk);
        o.fall = !wb_valid && !exc_misalign && !exc_bus;
    endtask

    task automatic compare(input string tag, input stim_t s, input exp_t e, input obs_t o);
        chk($sformatf("%s.stall_cycles", tag), 32'(o.stall), 32'(e.stall));
        chk($sformatf("%s.dmem_req", tag), 32'(o.req), 32'(e.req));
        if (e.req) begin
            chk($sformatf("%s.dmem_addr", tag), o.addr, e.addr);
            chk($sformatf("%s.dmem_be", tag), 32'(o.be), 32'(e.be));
            chk($sformatf("%s.dmem_we", tag), 32'(o.we), 32'(e.we));
            chk($sformatf("%s.dmem_stable", tag), 32'(o.stable), 32'h1);
            if (e.chk_wdata) chk($sformatf("%s.dmem_wdata", tag), o.wdata, e.wdata);
        end
        chk($sformatf("%s.wb_valid", tag), 32'(o.wbv), 32'h1);
        chk($sformatf("%s.wb_reg_write", tag), 32'(o.rw), 32'(e.rw));
        chk($sformatf("%s.exc_misalign", tag), 32'(o.mis), 32'(e.mis));
        chk($sformatf("%s.exc_bus", tag), 32'(o.bus), 32'(e.bus));
        if (e.chk_wb) begin
            chk($sformatf("%s.wb_data", tag), o.wb, e.wb);
            chk($sformatf("%s.wb_rd", tag), 32'(o.rd), 32'(s.rd));
        end
        chk($sformatf("%s.req_after", tag), 32'(o.req_after), 32'h0);
        chk($sformatf("%s.pulse_fall", tag), 32'(o.fall), 32'h1);
    endtask

    vec_t  vecs[12];
    stim_t s;
    exp_t  e;
    obs_t  o;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] f3_set[5];
        int         seen;
        f3_set = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        vecs[0]  = '{'{1'b0, 1'b0, 3'b000, 32'h12345678, 32'h0, 32'h0, 5'd5, 1'b1, 0},
                     '{0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0}};
        vecs[1]  = '{'{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 5'd6, 1'b1, 3},
                     '{3, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b0, 32'hFFFFFF80, 1'b1, 1'b1, 1'b0, 1'b0}};
        vecs[2]  = '{'{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 5'd7, 1'b1, 3},
                     '{3, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b0, 32'h00000080, 1'b1, 1'b1, 1'b0, 1'b0}};
        vecs[3]  = '{'{1'b0, 1'b1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0, 5'd8, 1'b1, 1},
                     '{1, 1'b1, 1'b1, 32'h200, 4'hC, 32'hBEEFBEEF, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[4]  = '{'{1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 5'd9, 1'b1, 1},
                     '{0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0}};
        vecs[5]  = '{'{1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 5'd10, 1'b1, 0},
                     '{15, 1'b1, 1'b0, 32'h300, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[6]  = '{'{1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 5'd10, 1'b1, 15},
                     '{15, 1'b1, 1'b0, 32'h300, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b0}};
        vecs[7]  = '{'{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 5'd11, 1'b1, 1},
                     '{1, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b0, 32'hFFFF8001, 1'b1, 1'b1, 1'b0, 1'b0}};
        vecs[8]  = '{'{1'b0, 1'b1, 3'b000, 32'h003, 32'h1234565A, 32'h0, 5'd1, 1'b1, 2},
                     '{2, 1'b1, 1'b1, 32'h000, 4'h8, 32'h5A5A5A5A, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[9]  = '{'{1'b1, 1'b1, 3'b010, 32'h400, 32'h11223344, 32'h0, 5'd2, 1'b1, 1},
                     '{1, 1'b1, 1'b1, 32'h400, 4'hF, 32'h11223344, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[10] = '{'{1'b1, 1'b0, 3'b101, 32'h101, 32'h0, 32'h0, 5'd3, 1'b1, 1},
                     '{0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0}};
        vecs[11] = '{'{1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80011234, 5'd12, 1'b0, 2},
                     '{2, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b0, 32'h00008001, 1'b1, 1'b0, 1'b0, 1'b0}};

        rst_n = 1'b0; in_valid = 1'b0; alu_result = 32'h0; store_data = 32'h0;
        mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'h0; rd = 5'h0; reg_write = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        #12;
        chk("reset.stall", 32'(stall), 32'h0);
        chk("reset.dmem", {dmem_addr[31:6], dmem_req, dmem_we, dmem_be}, 32'h0);
        chk("reset.dmem_wdata", dmem_wdata, 32'h0);
        chk("reset.wb", {wb_valid, wb_rd, wb_reg_write, exc_misalign, exc_bus}, 32'h0);
        chk("reset.wb_data", wb_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].s, o);
            compare($sformatf("vec%0d", i), vecs[i].s, vecs[i].e, o);
        end

        for (int i = 0; i < 60; i++) begin
            int kind;
            int pick;
            kind   = int'($urandom_range(0, 3));
            s.mr   = (kind == 1) || (kind == 3);
            s.mw   = (kind == 2) || (kind == 3);
            s.f3   = f3_set[$urandom_range(0, 4)];
            s.addr = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                if (s.f3[1]) s.addr[1:0] = 2'b00;
                else if (s.f3[0]) s.addr[0] = 1'b0;
            end
            s.sdata = $urandom; s.rdata = $urandom;
            s.rd = 5'($urandom); s.rw = 1'($urandom);
            pick = int'($urandom_range(0, 9));
            s.ack_at = (pick == 0) ? 0 : (pick == 9) ? TO : int'($urandom_range(1, 6));
            e = model(s);
            do_op(s, o);
            compare($sformatf("rand%0d", i), s, e, o);
        end

        // Ack while idle must not retire anything.
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = $urandom;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (wb_valid || stall || dmem_req) seen++;
        end
        dmem_ack = 1'b0;
        chk("idle_ack.ignored", 32'(seen), 32'h0);

        // New instruction offered during WAIT is ignored.
        @(negedge clk);
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        alu_result = 32'h500; rd = 5'd3; reg_write = 1'b1;
        @(negedge clk);
        mem_read = 1'b0; alu_result = 32'hDEAD0000; rd = 5'd7;
        seen = 0;
        @(negedge clk);
        if (wb_valid) seen++;
        chk("wait_in_valid.stall", 32'(stall), 32'h1);
        dmem_ack = 1'b1; dmem_rdata = 32'h13579BDF; in_valid = 1'b0;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("wait_in_valid.no_early_wb", 32'(seen), 32'h0);
        chk("wait_in_valid.wb_data", wb_data, 32'h13579BDF);
        chk("wait_in_valid.wb_rd", 32'(wb_rd), 32'd3);
        @(negedge clk);
        chk("wait_in_valid.no_extra_wb", 32'({wb_valid, stall}), 32'h0);

        // Reset in the middle of WAIT discards the transaction.
        in_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h600; rd = 5'd4;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_wait.pre_req", 32'(dmem_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wait.req_async", 32'(dmem_req), 32'h0);
        chk("rst_wait.stall_async", 32'(stall), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            dmem_ack = (k == 1);
            @(negedge clk);
            if (wb_valid || stall || dmem_req) seen++;
        end
        dmem_ack = 1'b0;
        chk("rst_wait.no_wb", 32'(seen), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
